// File: rtl/mcu_spi_regs.sv
// SPI mode-0 slave register bank for the MCU link. SCK, NSS and MOSI are
// oversampled in the clk domain and 40-bit frames are decoded into register reads and writes.
module mcu_spi_regs #(
  parameter logic [31:0] SYN_DATE = 32'h1911_0100,
  parameter logic [7:0]  FPGA_VER = 8'h00,
  parameter logic [31:0] CTRL_RST = 32'h0000_0000,
  parameter int          SYNC_STG = 2
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        spi_sck,
  input  logic        spi_nss,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [7:0]  dipsw,
  input  logic        pll_locked,
  output logic [31:0] ctrl,
  output logic        ctrl_wr
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t              state, state_nx;
  logic [SYNC_STG-1:0] sck_sync, nss_sync, mosi_sync;
  logic                sck_d, nss_d;
  logic [7:0]          dip_m, dip_s;
  logic                pll_m, pll_s;
  logic                sck_s, nss_s, mosi_s;
  logic                sck_rise, sck_fall, nss_rise, nss_fall;
  logic                start, abort, hdr_done, last_bit;
  logic [5:0]          bit_cnt;
  logic [31:0]         rx_sh, rd_shift, rd_val, wr_data, scratch;
  logic [6:0]          hdr_addr, wr_addr;
  logic                wr_flag, commit_pend;
  logic [7:0]          abort_cnt;

  assign sck_s    = sck_sync[SYNC_STG-1];
  assign nss_s    = nss_sync[SYNC_STG-1];
  assign mosi_s   = mosi_sync[SYNC_STG-1];
  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;
  assign nss_rise = nss_s & ~nss_d;
  assign nss_fall = ~nss_s & nss_d;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      sck_sync  <= '0;
      nss_sync  <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
      nss_d     <= 1'b1;
      dip_m     <= '0;
      dip_s     <= '0;
      pll_m     <= 1'b0;
      pll_s     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STG-2:0], spi_sck};
      nss_sync  <= {nss_sync[SYNC_STG-2:0], spi_nss};
      mosi_sync <= {mosi_sync[SYNC_STG-2:0], spi_mosi};
      sck_d     <= sck_s;
      nss_d     <= nss_s;
      dip_m     <= dipsw;
      dip_s     <= dip_m;
      pll_m     <= pll_locked;
      pll_s     <= pll_m;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    start    = 1'b0;
    abort    = 1'b0;
    hdr_done = 1'b0;
    last_bit = 1'b0;
    case (state)
      IDLE: if (nss_fall) begin
        state_nx = HDR;
        start    = 1'b1;
      end
      HDR: if (nss_rise) begin
        state_nx = IDLE;
        abort    = 1'b1;
      end else if (sck_rise && bit_cnt == 6'd7) begin
        state_nx = DATA;
        hdr_done = 1'b1;
      end
      DATA: if (nss_rise) begin
        state_nx = IDLE;
        abort    = 1'b1;
      end else if (sck_rise && bit_cnt == 6'd39) begin
        state_nx = DONE;
        last_bit = 1'b1;
      end
      DONE: if (nss_rise) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign hdr_addr = {rx_sh[5:0], mosi_s};

  always_comb begin
    rd_val = 32'h0;
    case (hdr_addr)
      7'h00: rd_val = SYN_DATE;
      7'h01: rd_val = {24'h0, FPGA_VER};
      7'h02: rd_val = {16'h0, dip_s, 7'h0, pll_s};
      7'h03: rd_val = ctrl;
      7'h04: rd_val = scratch;
      7'h05: rd_val = {24'h0, abort_cnt};
      default: rd_val = 32'h0;
    endcase
  end

  // The fall right after the 8th rise must not shift, otherwise bit 31 is lost
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bit_cnt     <= '0;
      rx_sh       <= '0;
      rd_shift    <= '0;
      wr_flag     <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      commit_pend <= 1'b0;
    end else begin
      commit_pend <= last_bit & wr_flag;
      if (start) begin
        bit_cnt <= '0;
        rx_sh   <= '0;
      end else if ((state == HDR || state == DATA) && sck_rise && !nss_rise) begin
        bit_cnt <= bit_cnt + 6'd1;
        rx_sh   <= {rx_sh[30:0], mosi_s};
      end
      if (hdr_done) begin
        wr_flag  <= rx_sh[6];
        wr_addr  <= hdr_addr;
        rd_shift <= rx_sh[6] ? 32'h0 : rd_val;
      end else if (state == DATA && sck_fall && bit_cnt > 6'd8) begin
        rd_shift <= {rd_shift[30:0], 1'b0};
      end
      if (last_bit) wr_data <= {rx_sh[30:0], mosi_s};
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ctrl      <= CTRL_RST;
      ctrl_wr   <= 1'b0;
      scratch   <= '0;
      abort_cnt <= '0;
    end else begin
      ctrl_wr <= 1'b0;
      if (commit_pend && wr_addr == 7'h03) begin
        ctrl    <= wr_data;
        ctrl_wr <= 1'b1;
      end
      if (commit_pend && wr_addr == 7'h04) scratch <= wr_data;
      if (commit_pend && wr_addr == 7'h05)       abort_cnt <= '0;
      else if (abort && abort_cnt != 8'hFF)      abort_cnt <= abort_cnt + 8'd1;
    end
  end

  assign spi_miso    = (state == DATA) & rd_shift[31];
  assign spi_miso_oe = (state != IDLE);

endmodule

// File: tb/tb_mcu_spi_regs.sv
// Bench for mcu_spi_regs: drives mode-0 frames at SCK = clk/8 and scores
// read data against a queue of expected values.
module tb_mcu_spi_regs;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        spi_sck = 1'b0;
  logic        spi_nss = 1'b1;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, spi_miso_oe;
  logic [7:0]  dipsw = 8'h00;
  logic        pll_locked = 1'b0;
  logic [31:0] ctrl;
  logic        ctrl_wr;

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  int          wr_pulses = 0;
  logic [31:0] exp_q[$];

  mcu_spi_regs dut (
    .clk(clk), .rst_b(rst_b), .spi_sck(spi_sck), .spi_nss(spi_nss),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .dipsw(dipsw), .pll_locked(pll_locked), .ctrl(ctrl), .ctrl_wr(ctrl_wr)
  );

  always #12.5 clk = ~clk;

  always @(posedge clk) if (ctrl_wr === 1'b1) wr_pulses++;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // rst_at >= 0 pulls reset before that bit; the frame is then abandoned
  task automatic applyStimulus(input logic w, input logic [6:0] addr, input logic [31:0] data,
                               input int npulses, input int rst_at, input logic [31:0] exp_rd,
                               input string tag);
    logic [39:0] frame;
    logic [31:0] rd;
    logic [31:0] q_exp;
    bit          was_reset;
    frame = {w, addr, data};
    rd = '0;
    was_reset = 1'b0;
    if (!w) exp_q.push_back(exp_rd);
    @(negedge clk);
    spi_nss = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < npulses; i++) begin
      if (i == rst_at) begin
        rst_b = 1'b0;
        spi_nss = 1'b1;
        spi_sck = 1'b0;
        #1;
        checkOutput({tag, "_rst_ctrl"}, ctrl, 32'h0);
        checkOutput({tag, "_rst_oe"}, {31'h0, spi_miso_oe}, 32'h0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        was_reset = 1'b1;
        break;
      end
      spi_mosi = (i < 40) ? frame[39-i] : 1'b0;
      repeat (4) @(negedge clk);
      if (i == 1) checkOutput({tag, "_oe"}, {31'h0, spi_miso_oe}, 32'h1);
      if (i >= 8 && i < 40) rd = {rd[30:0], spi_miso};
      spi_sck = 1'b1;
      repeat (4) @(negedge clk);
      spi_sck = 1'b0;
    end
    repeat (4) @(negedge clk);
    spi_nss = 1'b1;
    repeat (8) @(negedge clk);
    if (!w && !was_reset) begin
      q_exp = exp_q.pop_front();
      checkOutput(tag, rd, q_exp);
    end
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int pulses0;
    repeat (3) @(negedge clk);
    checkOutput("rst_ctrl", ctrl, 32'h0);
    checkOutput("rst_ctrl_wr", {31'h0, ctrl_wr}, 32'h0);
    checkOutput("rst_miso", {30'h0, spi_miso_oe, spi_miso}, 32'h0);
    rst_b = 1'b1;
    repeat (4) @(negedge clk);

    applyStimulus(1'b0, 7'h00, 32'h0, 40, -1, 32'h1911_0100, "rd_00");
    applyStimulus(1'b0, 7'h01, 32'h0, 40, -1, 32'h0000_0000, "rd_01");

    pulses0 = wr_pulses;
    applyStimulus(1'b1, 7'h03, 32'hA5A5_0001, 40, -1, 32'h0, "wr_03");
    checkOutput("ctrl_after_wr", ctrl, 32'hA5A5_0001);
    checkOutput("ctrl_wr_pulses", wr_pulses - pulses0, 32'd1);
    applyStimulus(1'b0, 7'h03, 32'h0, 40, -1, 32'hA5A5_0001, "rd_03");

    applyStimulus(1'b1, 7'h04, 32'hDEAD_BEEF, 20, -1, 32'h0, "wr_04_abort");
    applyStimulus(1'b0, 7'h04, 32'h0, 40, -1, 32'h0, "rd_04_scratch");
    applyStimulus(1'b0, 7'h05, 32'h0, 40, -1, 32'h1, "rd_05_one");
    applyStimulus(1'b1, 7'h05, 32'h1234_5678, 40, -1, 32'h0, "wr_05");
    applyStimulus(1'b0, 7'h05, 32'h0, 40, -1, 32'h0, "rd_05_clr");

    applyStimulus(1'b1, 7'h04, 32'h0F0F_3C3C, 40, -1, 32'h0, "wr_04");
    applyStimulus(1'b0, 7'h04, 32'h0, 40, -1, 32'h0F0F_3C3C, "rd_04");

    dipsw = 8'h81;
    pll_locked = 1'b1;
    repeat (4) @(negedge clk);
    applyStimulus(1'b0, 7'h02, 32'h0, 40, -1, 32'h0000_8101, "rd_02");
    applyStimulus(1'b0, 7'h7F, 32'h0, 40, -1, 32'h0, "rd_7f");
    pulses0 = wr_pulses;
    applyStimulus(1'b1, 7'h00, 32'hFFFF_FFFF, 40, -1, 32'h0, "wr_00");
    checkOutput("ro_wr_pulses", wr_pulses - pulses0, 32'd0);
    checkOutput("ro_ctrl", ctrl, 32'hA5A5_0001);
    applyStimulus(1'b0, 7'h00, 32'h0, 40, -1, 32'h1911_0100, "rd_00_again");

    applyStimulus(1'b1, 7'h03, 32'h0000_0001, 40, -1, 32'h0, "wr_03_one");
    checkOutput("ctrl_one", ctrl, 32'h1);
    applyStimulus(1'b1, 7'h03, 32'h1234_5678, 40, 30, 32'h0, "wr_03_rst");
    checkOutput("ctrl_post_rst", ctrl, 32'h0);
    pulses0 = wr_pulses;
    applyStimulus(1'b1, 7'h03, 32'hCAFE_F00D, 40, -1, 32'h0, "wr_03_fresh");
    checkOutput("ctrl_fresh", ctrl, 32'hCAFE_F00D);
    checkOutput("fresh_pulses", wr_pulses - pulses0, 32'd1);

    applyStimulus(1'b1, 7'h04, 32'h5555_AAAA, 10, -1, 32'h0, "wr_04_abort2");
    pulses0 = wr_pulses;
    applyStimulus(1'b1, 7'h03, 32'h0000_00FF, 45, -1, 32'h0, "wr_03_45");
    checkOutput("ctrl_45", ctrl, 32'h0000_00FF);
    checkOutput("pulses_45", wr_pulses - pulses0, 32'd1);
    applyStimulus(1'b0, 7'h05, 32'h0, 40, -1, 32'h1, "rd_05_after45");
    applyStimulus(1'b0, 7'h03, 32'h0, 40, -1, 32'h0000_00FF, "rd_03_45");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
